// File: rtl/dcache_wb_buffer_pkg.sv
// rtl/dcache_wb_buffer_pkg.sv - shared AXI encodings, write-buffer ID and drain FSM state type
package dcache_wb_buffer_pkg;

    localparam logic [1:0] AXBURST_INCR = 2'b01;
    localparam logic [2:0] AXSIZE_4B    = 3'b010;
    localparam logic [3:0] WB_AXI_ID    = 4'h1;

    // Byte-offset width inside one cache line (32-bit words).
    function automatic int line_off_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } drain_state_e;

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// rtl/dcache_wb_buffer_if.sv - AXI write-channel bundle (AW, W, B) between buffer and interconnect
interface dcache_wb_buffer_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_wb_buffer_fifo.sv
// rtl/dcache_wb_buffer_fifo.sv - evicted-line FIFO with youngest-match line lookup
module wbuf_line_fifo
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enq_i,
    input  logic [31:0]               enq_addr_i,
    input  logic [LINE_WORDS*32-1:0]  enq_line_i,
    input  logic                      deq_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [31:0]               head_addr_o,
    output logic [LINE_WORDS*32-1:0]  head_line_o,
    input  logic [31:0]               chk_addr_i,
    output logic                      chk_hit_o,
    output logic [LINE_WORDS*32-1:0]  chk_line_o
);
    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = IW + 1;
    localparam int OFF = line_off_w(LINE_WORDS);

    logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
    logic [31:0]               addr_q [DEPTH];
    logic [LINE_WORDS*32-1:0]  line_q [DEPTH];
    logic [PW-1:0]             used;
    logic [IW-1:0]             idx;
    logic                      unused_low_bits;

    assign unused_low_bits = ^{enq_addr_i[OFF-1:0], chk_addr_i[OFF-1:0]};

    assign full_o  = (head_q[IW] != tail_q[IW]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign empty_o = (head_q == tail_q);
    assign used    = tail_q - head_q;
    assign head_addr_o = addr_q[head_q[IW-1:0]];
    assign head_line_o = line_q[head_q[IW-1:0]];

    assign head_d = deq_i ? head_q + PW'(1) : head_q;
    assign tail_d = enq_i ? tail_q + PW'(1) : tail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Payload storage needs no reset: every read is qualified by the pointers.
    always_ff @(posedge clk) begin
        if (enq_i) begin
            addr_q[tail_q[IW-1:0]] <= {enq_addr_i[31:OFF], OFF'(0)};
            line_q[tail_q[IW-1:0]] <= enq_line_i;
        end
    end

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        chk_hit_o  = 1'b0;
        chk_line_o = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q[IW-1:0] + IW'(i);
            if ((PW'(i) < used) && (addr_q[idx][31:OFF] == chk_addr_i[31:OFF])) begin
                chk_hit_o  = 1'b1;
                chk_line_o = line_q[idx];
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buffer.sv
// rtl/dcache_wb_buffer.sv - dirty-line write-back buffer draining to AXI as INCR bursts
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int         DEPTH      = 2,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = WB_AXI_ID
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [31:0]               wb_addr,
    input  logic [LINE_WORDS*32-1:0]  wb_line,
    input  logic [31:0]               chk_addr,
    output logic                      chk_hit,
    output logic [LINE_WORDS*32-1:0]  chk_line,
    output logic                      wb_empty,
    output logic                      bresp_err,
    dcache_wb_buffer_if.master        axi
);
    localparam int CW = $clog2(LINE_WORDS);

    drain_state_e              state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      fifo_full, fifo_empty, retire, wlast_w;
    logic [31:0]               head_addr;
    logic [LINE_WORDS*32-1:0]  head_line;
    logic                      unused_bid;

    assign unused_bid = ^axi.bid;
    assign wb_ready   = !fifo_full;
    assign retire     = (state_q == ST_B) && axi.bvalid;
    assign wlast_w    = (cnt_q == CW'(LINE_WORDS - 1));
    assign wb_empty   = fifo_empty && (state_q == ST_IDLE);

    wbuf_line_fifo #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_fifo (
        .clk         (aclk),
        .rst_n       (aresetn),
        .enq_i       (wb_valid && !fifo_full),
        .enq_addr_i  (wb_addr),
        .enq_line_i  (wb_line),
        .deq_i       (retire),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (head_addr),
        .head_line_o (head_line),
        .chk_addr_i  (chk_addr),
        .chk_hit_o   (chk_hit),
        .chk_line_o  (chk_line)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                state_d = ST_AW;
                cnt_d   = '0;
            end
            ST_AW: if (axi.awready) state_d = ST_W;
            ST_W: if (axi.wready) begin
                cnt_d = cnt_q + CW'(1);
                if (wlast_w) begin
                    state_d = ST_B;
                    cnt_d   = '0;
                end
            end
            ST_B: if (axi.bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload comes straight from the head entry, which cannot change before
    // its B handshake, so valid/payload stay stable until accepted.
    always_comb begin
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awsize  = '0;
        axi.awburst = '0;
        axi.awvalid = 1'b0;
        axi.wid     = '0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        bresp_err   = 1'b0;
        case (state_q)
            ST_AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = head_addr;
                axi.awlen   = 8'(LINE_WORDS - 1);
                axi.awsize  = AXSIZE_4B;
                axi.awburst = AXBURST_INCR;
                axi.awid    = AXI_ID;
            end
            ST_W: begin
                axi.wvalid = 1'b1;
                axi.wdata  = head_line[32*int'(cnt_q) +: 32];
                axi.wstrb  = 4'hf;
                axi.wlast  = wlast_w;
                axi.wid    = AXI_ID;
            end
            ST_B: begin
                axi.bready = 1'b1;
                bresp_err  = axi.bvalid && (axi.bresp != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb/tb_dcache_wb_buffer.sv - directed and table-driven self-checking bench for dcache_wb_buffer
module tb_dcache_wb_buffer;
    localparam int LW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          wb_valid;
    logic          wb_ready;
    logic [31:0]   wb_addr;
    logic [LW*32-1:0] wb_line;
    logic [31:0]   chk_addr;
    logic          chk_hit;
    logic [LW*32-1:0] chk_line;
    logic          wb_empty;
    logic          bresp_err;
    logic          rand_en;

    dcache_wb_buffer_if axi();

    dcache_wb_buffer #(.DEPTH(2), .LINE_WORDS(LW), .AXI_ID(4'h1)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_line   (wb_line),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .chk_line  (chk_line),
        .wb_empty  (wb_empty),
        .bresp_err (bresp_err),
        .axi       (axi)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [LW*32-1:0] act, input logic [LW*32-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW*32-1:0] make_line(input logic [31:0] base);
        logic [LW*32-1:0] l;
        for (int k = 0; k < LW; k++) l[32*k +: 32] = base + 32'h11 * 32'(k);
        return l;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference model of buffered lines plus AXI protocol observer.
    typedef struct {
        logic [31:0]      addr;
        logic [LW*32-1:0] line;
    } ent_t;
    ent_t        exp_q[$];
    int          beat = 0;
    int          bcnt = 0;
    bit          aw_hold = 0, w_hold = 0;
    logic [31:0] aw_hold_addr, w_hold_data;

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            beat    = 0;
            aw_hold = 0;
            w_hold  = 0;
        end else begin
            if (aw_hold) begin
                chk("aw_hold_valid", 256'(axi.awvalid), 256'(1));
                chk("aw_hold_addr", 256'(axi.awaddr), 256'(aw_hold_addr));
            end
            if (w_hold) begin
                chk("w_hold_valid", 256'(axi.wvalid), 256'(1));
                chk("w_hold_data", 256'(axi.wdata), 256'(w_hold_data));
            end
            aw_hold      = axi.awvalid && !axi.awready;
            aw_hold_addr = axi.awaddr;
            w_hold       = axi.wvalid && !axi.wready;
            w_hold_data  = axi.wdata;
            if (wb_valid && wb_ready) exp_q.push_back('{wb_addr & 32'hffff_ffe0, wb_line});
            if (axi.awvalid && axi.awready) begin
                if (exp_q.size() == 0) chk("aw_without_entry", 256'(0), 256'(1));
                else begin
                    chk("awaddr", 256'(axi.awaddr), 256'(exp_q[0].addr));
                    chk("awlen", 256'(axi.awlen), 256'(7));
                    chk("awsize", 256'(axi.awsize), 256'(2));
                    chk("awburst", 256'(axi.awburst), 256'(1));
                    chk("awid", 256'(axi.awid), 256'(1));
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_q.size() == 0) chk("w_without_entry", 256'(0), 256'(1));
                else begin
                    chk("wdata", 256'(axi.wdata), 256'(exp_q[0].line[32*beat +: 32]));
                    chk("wlast", 256'(axi.wlast), 256'(beat == LW - 1));
                    chk("wstrb", 256'(axi.wstrb), 256'(4'hf));
                    chk("wid", 256'(axi.wid), 256'(1));
                end
                beat = (beat == LW - 1) ? 0 : beat + 1;
            end
            if (axi.bvalid && axi.bready) begin
                bcnt++;
                chk("b_after_last_beat", 256'(beat), 256'(0));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        if (rand_en) begin
            axi.wready = 1'($urandom_range(0, 1));
            axi.bvalid = 1'($urandom_range(0, 1));
        end
    end

    task automatic offer(input logic [31:0] a, input logic [LW*32-1:0] l);
        int n = 0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_line  = l;
        while (!wb_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!wb_ready) chk("offer_timeout", 256'(0), 256'(1));
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!wb_empty && n < 5000) begin
            tick();
            n++;
        end
        chk(name, 256'(wb_empty), 256'(1));
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic             hit;
        logic [LW*32-1:0] line;
    } lk_vec_t;
    lk_vec_t lk[7];

    initial begin
        int errs, n, b0;
        bit found, first;

        lk[0] = '{32'h0000_4000, 1'b1, make_line(32'hC000_0000)};
        lk[1] = '{32'h0000_401f, 1'b1, make_line(32'hC000_0000)};
        lk[2] = '{32'h0000_4020, 1'b1, make_line(32'hD000_0000)};
        lk[3] = '{32'h0000_403c, 1'b1, make_line(32'hD000_0000)};
        lk[4] = '{32'h0000_4040, 1'b0, '0};
        lk[5] = '{32'h0000_3fe0, 1'b0, '0};
        lk[6] = '{32'hc000_4000, 1'b0, '0};

        aresetn = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_line = '0; chk_addr = '0;
        rand_en = 1'b0;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
        axi.bresp = 2'b00; axi.bid = 4'h1;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        chk("rst_wb_ready", 256'(wb_ready), 256'(1));
        chk("rst_wb_empty", 256'(wb_empty), 256'(1));
        chk("rst_awvalid", 256'(axi.awvalid), 256'(0));
        chk("rst_wvalid", 256'(axi.wvalid), 256'(0));
        chk("rst_bready", 256'(axi.bready), 256'(0));
        chk("rst_awaddr", 256'(axi.awaddr), 256'(0));
        chk("rst_wdata", 256'(axi.wdata), 256'(0));
        chk("rst_chk_hit", 256'(chk_hit), 256'(0));
        chk("rst_bresp_err", 256'(bresp_err), 256'(0));

        // single line, no backpressure, cycle-exact
        offer(32'h0000_1040, make_line(32'h0));
        chk("t1_idle_cycle", 256'(axi.awvalid), 256'(0));
        tick();
        chk("t1_awvalid", 256'(axi.awvalid), 256'(1));
        chk("t1_awaddr", 256'(axi.awaddr), 256'(32'h1040));
        chk("t1_awlen", 256'(axi.awlen), 256'(7));
        tick();
        for (int k = 0; k < LW; k++) begin
            chk("t1_wvalid", 256'(axi.wvalid), 256'(1));
            chk("t1_wdata", 256'(axi.wdata), 256'(32'h11 * 32'(k)));
            chk("t1_wlast", 256'(axi.wlast), 256'(k == LW - 1));
            tick();
        end
        chk("t1_bready", 256'(axi.bready), 256'(1));
        chk("t1_not_empty_in_b", 256'(wb_empty), 256'(0));
        chk("t1_no_err", 256'(bresp_err), 256'(0));
        tick();
        chk("t1_empty_after_b", 256'(wb_empty), 256'(1));

        // fill, lookup table, stall third offer, release
        axi.awready = 1'b0;
        offer(32'h0000_4000, make_line(32'hC000_0000));
        offer(32'h0000_4020, make_line(32'hD000_0000));
        chk("t2_full_ready0", 256'(wb_ready), 256'(0));
        foreach (lk[i]) begin
            chk_addr = lk[i].addr;
            #1;
            chk($sformatf("lk%0d_hit", i), 256'(chk_hit), 256'(lk[i].hit));
            chk($sformatf("lk%0d_line", i), chk_line, lk[i].line);
            tick();
        end
        wb_valid = 1'b1; wb_addr = 32'h0000_4040; wb_line = make_line(32'hE000_0000);
        repeat (3) begin
            tick();
            chk("t2_stall_ready", 256'(wb_ready), 256'(0));
            chk("t2_aw_waiting", 256'(axi.awaddr), 256'(32'h4000));
        end
        axi.awready = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (axi.bvalid && axi.bready) begin
                chk("t2_ready_at_b", 256'(wb_ready), 256'(0));
                tick();
                chk("t2_ready_after_b", 256'(wb_ready), 256'(1));
                found = 1;
            end else tick();
        end
        chk("t2_b_seen", 256'(found), 256'(1));
        tick();
        wb_valid = 1'b0;
        wait_empty("t2_drained");

        // duplicate lines: youngest wins, both drain
        axi.awready = 1'b0;
        chk_addr = 32'h0000_2004;
        offer(32'h0000_2000, make_line(32'hA000_0000));
        offer(32'h0000_2000, make_line(32'hB000_0000));
        chk("t3_hit", 256'(chk_hit), 256'(1));
        chk("t3_youngest", chk_line, make_line(32'hB000_0000));
        axi.awready = 1'b1;
        wait_empty("t3_drained");
        chk("t3_hit_gone", 256'(chk_hit), 256'(0));
        chk("t3_line_zero", chk_line, '0);

        // random W/B backpressure over 20 lines
        b0 = bcnt;
        rand_en = 1'b1;
        for (int i = 0; i < 20; i++)
            offer(32'h0001_0000 + 32'(i % 7) * 32'h40 + 32'(i % 3) * 4, make_line((32'(i) << 24) | 32'h100));
        wait_empty("t4_drained");
        rand_en = 1'b0;
        axi.wready = 1'b1; axi.bvalid = 1'b1;
        chk("t4_lines_retired", 256'(bcnt - b0), 256'(20));

        // error response on first B
        b0 = bcnt;
        axi.bresp = 2'b10;
        offer(32'h0000_5000, make_line(32'h5000_0000));
        offer(32'h0000_5020, make_line(32'h5020_0000));
        errs = 0; n = 0; first = 1;
        while (!wb_empty && n < 200) begin
            if (bresp_err) errs++;
            if (first && axi.bready) begin
                chk("t5_err_on_b", 256'(bresp_err), 256'(1));
                first = 0;
                tick();
                axi.bresp = 2'b00;
                chk("t5_err_one_cycle", 256'(bresp_err), 256'(0));
            end else tick();
            n++;
        end
        chk("t5_err_count", 256'(errs), 256'(1));
        chk("t5_empty", 256'(wb_empty), 256'(1));
        chk("t5_both_retired", 256'(bcnt - b0), 256'(2));

        // reset on beat 3
        axi.bvalid = 1'b0;
        offer(32'h0000_6000, make_line(32'h6000_0000));
        offer(32'h0000_6020, make_line(32'h6020_0000));
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (axi.wvalid && axi.wdata == 32'h6000_0022) begin
                aresetn = 1'b0;
                found = 1;
            end else tick();
        end
        chk("t6_beat3_seen", 256'(found), 256'(1));
        chk_addr = 32'h0000_6000;
        tick();
        chk("t6_wvalid", 256'(axi.wvalid), 256'(0));
        chk("t6_empty", 256'(wb_empty), 256'(1));
        chk("t6_chk_hit", 256'(chk_hit), 256'(0));
        chk("t6_awvalid", 256'(axi.awvalid), 256'(0));
        aresetn = 1'b1;
        axi.bvalid = 1'b1;
        repeat (3) tick();
        chk("t6_still_empty", 256'(wb_empty), 256'(1));
        chk("t6_no_aw", 256'(axi.awvalid), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
